// File: rtl/object_motion_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// object_motion_engine
//
// Fixed-point kinematics store for the Asteroids game. Holds position
// (integer + sub-pixel fraction), signed velocity and an active flag for
// NUM_OBJ object slots. A step request sweeps all slots, one slot per cycle,
// adding velocity to position on both axes with toroidal screen wrap.
//
// Build option:
//   EDGE_CLAMP_EN - when defined, out-of-range results clamp to the screen
//                   edge per axis and that axis's velocity is zeroed instead
//                   of wrapping around.
//
// Ports:
//   move_clk     in   game clock
//   reset_n      in   asynchronous reset, asserted when high
//   step         in   one-cycle request to advance all objects
//   busy         out  sweep in progress (SWEEP or DONE)
//   done         out  one-cycle pulse after the last slot is updated
//   spawn_valid  in   spawn request
//   spawn_ready  out  spawn accepted when spawn_valid && spawn_ready
//   spawn_idx    in   target slot for spawn
//   spawn_x/y    in   initial integer position (fraction cleared)
//   spawn_vx/vy  in   signed velocity, sub-pixel units per step
//   kill_valid   in   deactivate slot kill_idx at the next edge
//   kill_idx     in   slot to kill
//   rd_idx       in   read select
//   rd_x/rd_y    out  integer position of slot rd_idx (1-cycle latency)
//   rd_active    out  active flag of slot rd_idx (1-cycle latency)
//   dbg_state    out  current FSM state (0 IDLE, 1 SWEEP, 2 DONE)
// -----------------------------------------------------------------------------
module object_motion_engine #(
    parameter int NUM_OBJ  = 4,
    parameter int IDX_W    = 2,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int POS_W    = 9,
    parameter int FRAC_W   = 4,
    parameter int VEL_W    = 8
) (
    input  logic             move_clk,
    input  logic             reset_n,
    input  logic             step,
    output logic             busy,
    output logic             done,
    input  logic             spawn_valid,
    output logic             spawn_ready,
    input  logic [IDX_W-1:0] spawn_idx,
    input  logic [POS_W-1:0] spawn_x,
    input  logic [POS_W-1:0] spawn_y,
    input  logic [VEL_W-1:0] spawn_vx,
    input  logic [VEL_W-1:0] spawn_vy,
    input  logic             kill_valid,
    input  logic [IDX_W-1:0] kill_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [POS_W-1:0] rd_x,
    output logic [POS_W-1:0] rd_y,
    output logic             rd_active,
    output logic [1:0]       dbg_state
);

    localparam int PW = POS_W + FRAC_W;  // stored position width
    localparam int SW = PW + 1;          // signed working width for the sum

    localparam logic signed [SW-1:0] LIM_X = SW'(SCREEN_W << FRAC_W);
    localparam logic signed [SW-1:0] LIM_Y = SW'(SCREEN_H << FRAC_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_cnt;

    logic [PW-1:0]       r_px  [NUM_OBJ];
    logic [PW-1:0]       r_py  [NUM_OBJ];
    logic [VEL_W-1:0]    r_vx  [NUM_OBJ];
    logic [VEL_W-1:0]    r_vy  [NUM_OBJ];
    logic [NUM_OBJ-1:0]  r_act;

    logic [POS_W-1:0]    r_rd_x;
    logic [POS_W-1:0]    r_rd_y;
    logic                r_rd_active;

    logic                w_spawn_fire;
    logic                w_sweep_en;
    logic [PW:0]         w_x_res;   // {edge_hit, new_position}
    logic [PW:0]         w_y_res;

    // One axis of the update. The sum is formed one bit wider than the stored
    // position so an underflow shows up as a negative value; a single
    // correction is enough because |velocity| is always smaller than the limit.
    // Bit PW of the result flags an edge clamp (always 0 in wrap mode).
    function automatic logic [PW:0] axis_step(
        input logic [PW-1:0]        pos,
        input logic [VEL_W-1:0]     vel,
        input logic signed [SW-1:0] lim
    );
        logic signed [SW-1:0] sum;
        logic                 hit;
        sum = $signed({1'b0, pos}) + $signed({{(SW-VEL_W){vel[VEL_W-1]}}, vel});
        hit = 1'b0;
`ifdef EDGE_CLAMP_EN
        if (sum[SW-1]) begin
            sum = '0;
            hit = 1'b1;
        end else if (sum >= lim) begin
            sum = lim - SW'(1 << FRAC_W);
            hit = 1'b1;
        end
`else
        if (sum[SW-1]) begin
            sum = sum + lim;
        end else if (sum >= lim) begin
            sum = sum - lim;
        end
`endif
        return {hit, sum[PW-1:0]};
    endfunction

    assign w_x_res = axis_step(r_px[r_cnt], r_vx[r_cnt], LIM_X);
    assign w_y_res = axis_step(r_py[r_cnt], r_vy[r_cnt], LIM_Y);

    // Spawn handshake: a request transfers in any cycle where spawn_valid and
    // spawn_ready are both high. spawn_ready is only offered in IDLE when no
    // step is being requested, so step always wins over spawn, and it is held
    // low while reset is asserted.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        spawn_ready  = 1'b0;
        w_sweep_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                spawn_ready = ~step & ~reset_n;
                if (step) w_next_state = S_SWEEP;
            end
            S_SWEEP: begin
                busy       = 1'b1;
                w_sweep_en = 1'b1;
                if (r_cnt == IDX_W'(NUM_OBJ - 1)) w_next_state = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_spawn_fire = spawn_valid & spawn_ready;

    always_ff @(posedge move_clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE) r_cnt <= '0;
            else if (r_state == S_SWEEP) r_cnt <= r_cnt + 1'b1;
        end
    end

    // Slot storage. Inactive slots are skipped but still take their sweep
    // cycle. A kill to the slot being swept (or spawned) in the same cycle
    // wins: the slot goes inactive and the swept position is not written.
    always_ff @(posedge move_clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
            r_act <= '0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (w_spawn_fire && spawn_idx == IDX_W'(i)) begin
                    r_px[i]  <= {spawn_x, {FRAC_W{1'b0}}};
                    r_py[i]  <= {spawn_y, {FRAC_W{1'b0}}};
                    r_vx[i]  <= spawn_vx;
                    r_vy[i]  <= spawn_vy;
                    r_act[i] <= 1'b1;
                end else if (w_sweep_en && r_cnt == IDX_W'(i) && r_act[i] &&
                             !(kill_valid && kill_idx == IDX_W'(i))) begin
                    r_px[i] <= w_x_res[PW-1:0];
                    r_py[i] <= w_y_res[PW-1:0];
                    if (w_x_res[PW]) r_vx[i] <= '0;
                    if (w_y_res[PW]) r_vy[i] <= '0;
                end
                if (kill_valid && kill_idx == IDX_W'(i)) r_act[i] <= 1'b0;
            end
        end
    end

    // Read port samples the pre-edge slot contents every cycle.
    always_ff @(posedge move_clk or posedge reset_n) begin
        if (reset_n) begin
            r_rd_x      <= '0;
            r_rd_y      <= '0;
            r_rd_active <= 1'b0;
        end else begin
            r_rd_x      <= r_px[rd_idx][PW-1:FRAC_W];
            r_rd_y      <= r_py[rd_idx][PW-1:FRAC_W];
            r_rd_active <= r_act[rd_idx];
        end
    end

    assign rd_x      = r_rd_x;
    assign rd_y      = r_rd_y;
    assign rd_active = r_rd_active;
    assign dbg_state = r_state;

endmodule
